// File: rtl/dcache_banked_tile_if.sv
// Tile request/response bundle between the regfile/DMA arbiter and the banked tile.
// Widths derive from the same parameters as dcache_banked_tile.
interface dcache_banked_tile_if #(
    parameter int SZ     = 4,
    parameter int LOGCNT = 5,
    parameter int BITS   = 18,
    parameter int DLOG   = 10
) ();
    localparam int E  = SZ * SZ;
    localparam int AW = DLOG + LOGCNT;

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [AW-1:0]       req_addr;
    logic [AW-1:0]       req_stride_x;
    logic [AW-1:0]       req_stride_y;
    logic [BITS*E-1:0]   req_dat_w;
    logic                rsp_valid;
    logic [BITS*E-1:0]   rsp_dat_r;
    logic [15:0]         conflict_cnt;

    modport master (
        output req_valid, req_we, req_addr,
        output req_stride_x, req_stride_y, req_dat_w,
        input  req_ready, rsp_valid, rsp_dat_r, conflict_cnt
    );

    modport slave (
        input  req_valid, req_we, req_addr,
        input  req_stride_x, req_stride_y, req_dat_w,
        output req_ready, rsp_valid, rsp_dat_r, conflict_cnt
    );
endinterface

// File: rtl/dcache_banked_tile.sv
// Banked SZxSZ tile memory: strided element addressing, conflict-replay passes,
// one completion pulse per tile.
module dcache_banked_tile #(
    parameter int SZ     = 4,
    parameter int LOGCNT = 5,
    parameter int BITS   = 18,
    parameter int DLOG   = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_banked_tile_if.slave  bus
);
    localparam int E     = SZ * SZ;
    localparam int CNT   = 1 << LOGCNT;
    localparam int AW    = DLOG + LOGCNT;
    localparam int DEPTH = 1 << DLOG;
    localparam int PW    = $clog2(E + 1);

    typedef enum logic [1:0] {IDLE, ADDR, PASS, DRAIN} state_t;

    state_t             state_q;
    logic               we_q;
    logic [AW-1:0]      base_q;
    logic [AW-1:0]      sx_q;
    logic [AW-1:0]      sy_q;
    logic [BITS*E-1:0]  wdat_q;
    logic [AW-1:0]      a_q [E];
    logic [E-1:0]       pend_q;
    logic [E-1:0]       srv_q;
    logic [PW-1:0]      npass_q;
    logic               rsp_valid_q;
    logic [BITS*E-1:0]  rsp_q;
    logic [15:0]        cc_q;

    logic [BITS-1:0]    mem_q [CNT][DEPTH];
    logic [BITS-1:0]    rd_q  [CNT];

    logic [AW-1:0]      a_d [E];
    logic [E-1:0]       win;
    logic [E-1:0]       served;
    logic [CNT-1:0]     b_en;
    logic [DLOG-1:0]    b_row [CNT];
    logic [BITS-1:0]    b_wd  [CNT];
    logic               pass_done;
    logic [BITS*E-1:0]  merged;
    logic [16:0]        cc_sum;

    always_comb begin
        for (int k = 0; k < E; k++) begin
            a_d[k] = base_q
                   + AW'(k % SZ) * sx_q
                   + AW'(k / SZ) * sy_q;
        end
    end

    // Per bank: lowest pending index wins; its exact address is served as a group.
    always_comb begin
        win    = '0;
        served = '0;
        b_en   = '0;
        for (int b = 0; b < CNT; b++) begin
            b_row[b] = '0;
            b_wd[b]  = '0;
        end
        for (int k = 0; k < E; k++) begin
            win[k] = pend_q[k];
            for (int j = 0; j < E; j++) begin
                if (j < k && pend_q[j] &&
                    a_q[j][LOGCNT-1:0] == a_q[k][LOGCNT-1:0])
                    win[k] = 1'b0;
            end
        end
        for (int k = 0; k < E; k++) begin
            for (int j = 0; j < E; j++) begin
                if (win[j] && pend_q[k] && a_q[j] == a_q[k])
                    served[k] = 1'b1;
            end
        end
        // Ascending scan leaves the highest served index as the write data.
        for (int k = 0; k < E; k++) begin
            if (served[k]) begin
                b_en[a_q[k][LOGCNT-1:0]]  = 1'b1;
                b_row[a_q[k][LOGCNT-1:0]] = a_q[k][AW-1:LOGCNT];
                b_wd[a_q[k][LOGCNT-1:0]]  = wdat_q[BITS*k +: BITS];
            end
        end
    end

    assign pass_done = ((pend_q & ~served) == '0);
    assign cc_sum    = {1'b0, cc_q} + 17'(npass_q);

    // Bank read data lands one cycle after its pass; broadcast to all served elements.
    always_comb begin
        merged = rsp_q;
        for (int k = 0; k < E; k++) begin
            if (srv_q[k])
                merged[BITS*k +: BITS] = rd_q[a_q[k][LOGCNT-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < CNT; b++) begin
            if (state_q == PASS && b_en[b]) begin
                if (we_q)
                    mem_q[b][b_row[b]] <= b_wd[b];
                else
                    rd_q[b] <= mem_q[b][b_row[b]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            base_q      <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            wdat_q      <= '0;
            for (int k = 0; k < E; k++) a_q[k] <= '0;
            pend_q      <= '0;
            srv_q       <= '0;
            npass_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            cc_q        <= '0;
        end else begin
            srv_q <= '0;
            rsp_q <= merged;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        base_q  <= bus.req_addr;
                        sx_q    <= bus.req_stride_x;
                        sy_q    <= bus.req_stride_y;
                        wdat_q  <= bus.req_dat_w;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    for (int k = 0; k < E; k++) a_q[k] <= a_d[k];
                    pend_q  <= '1;
                    npass_q <= '0;
                    state_q <= PASS;
                end
                PASS: begin
                    pend_q  <= pend_q & ~served;
                    npass_q <= npass_q + 1'b1;
                    srv_q   <= we_q ? '0 : served;
                    if (pass_done) begin
                        state_q     <= DRAIN;
                        rsp_valid_q <= 1'b1;
                        cc_q        <= cc_sum[16] ? 16'hFFFF : cc_sum[15:0];
                    end
                end
                DRAIN: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_dat_r    = merged;
    assign bus.conflict_cnt = cc_q;
endmodule
